mole_game_engine: RTL
=====================

Name: mole_game_engine

Overview:
- Parametrised, fully synchronous successor to the three-mole display/player pair: one block owns mole selection, show/gap timing, button judging and scoring for NUM_MOLES targets.
- Sits between debounced board buttons and the LED/HEX outputs.
- The level FSM drives the speed and gap inputs.
- The score output feeds the existing seven_segment_decoder instances.

Parameters:
- NUM_MOLES, 3, number of moles/buttons (2..16)
- LFSR_WIDTH, 8, random generator width (4..16, must exceed clog2(NUM_MOLES))
- LFSR_SEED, 8'hA5, nonzero reset value of the LFSR
- CNT_WIDTH, 28, width of the speed/gap timers
- SCORE_WIDTH, 8, width of score and miss counters

Ports:
- clock  in  1  system clock; every register is updated on its rising edge
- reset  in  1  synchronous, active-high; overrides everything else
- game  in  1  level; 1 = play enabled
- buttons  in  NUM_MOLES  debounced button levels, bit i = mole i
- speed  in  CNT_WIDTH  mole on-time, in cycles minus 1
- gap  in  CNT_WIDTH  dark time between moles, in cycles minus 1
- moles  out  NUM_MOLES  one-hot (or zero) mole LEDs, registered
- score  out  SCORE_WIDTH  current score
- miss_count  out  SCORE_WIDTH  timeouts this game, saturating
- hit_pulse  out  1  one-cycle pulse on a correct hit
- miss_pulse  out  1  one-cycle pulse on a timeout
- active  out  1  high in GAP or SHOW

Behaviour:
- Reset values: state=IDLE, moles=0, score=0, miss_count=0, pulses=0, LFSR=LFSR_SEED, prev_idx=0, btn_q=0.
- LFSR:
  - Fibonacci XOR, maximal-length taps taken from the package.
  - Advances every cycle regardless of state; never reaches zero.
- Button edges:
  - btn_q registers buttons.
  - edge = buttons & ~btn_q.
  - Edges are judged in the same cycle they are detected.
- FSM states: IDLE, GAP, SHOW.
- IDLE:
  - moles=0.
  - On game=1: clear score and miss_count, load timer with gap, go to GAP.
- GAP:
  - moles=0; edges are ignored.
  - Timer decrements each cycle.
  - When the timer reaches 0: pick a mole, load timer with speed, go to SHOW. GAP therefore lasts gap+1 cycles.
- Pick:
  - idx = LFSR[IW-1:0], with IW = clog2(NUM_MOLES).
  - If idx >= NUM_MOLES, idx -= NUM_MOLES.
  - If idx == prev_idx, idx = (idx+1) wraps to 0 at NUM_MOLES.
  - Then prev_idx = idx, and moles = 1<<idx from the first SHOW cycle.
- SHOW, in priority order:
  - Hit: edge == moles exactly. Score +1, saturating at all-ones. hit_pulse=1. Clear moles, load gap, go to GAP.
  - Wrong press: edge != 0 and edge != moles. This includes the lit button pressed together with others. Score -1, floored at 0. Stay in SHOW; the timer continues.
  - Timeout: timer == 0 with no edge. miss_count +1, saturating. miss_pulse=1. Clear moles, load gap, go to GAP. SHOW lasts at most speed+1 cycles.
  - Edge on the final timer cycle: judged as hit or wrong. A wrong press on the final cycle applies the penalty and then times out the same cycle, so both the decrement and the miss occur.
- game=0 in any state:
  - Go to IDLE next cycle; moles=0.
  - score and miss_count are held for display.
- speed and gap are sampled only when the timer is loaded; changes mid-interval have no effect until the next load.
- speed=0 or gap=0 is legal and gives a single-cycle interval.
- reset mid-operation returns to the reset values on the next edge; LFSR_SEED is reloaded.
- Latency:
  - A button edge in SHOW updates score/moles/hit_pulse one cycle after the button level rises: one cycle for btn_q plus the registered outputs.
- Outputs are all registered; there are no combinational paths from input to output.

Decomposition:
- Package mole_game_pkg:
  - state enum (IDLE/GAP/SHOW)
  - function lfsr_taps(width) returning the tap mask for 4..16
  - saturating inc/dec helper functions
- Sub-module lfsr_rng:
  - parameters WIDTH, SEED
  - ports clock, reset, value
- The engine holds the FSM, timer, picker and scorer.

Test Plan:
- reset, then game=1 with gap=3, speed=9 -> active=1, moles=0 for 4 cycles, then exactly one moles bit set for up to 10 cycles; score=0.
- Raise the button matching the lit mole on SHOW cycle 2 -> next cycle hit_pulse=1, score=1, moles=0, GAP begins.
- score=2, lit mole 0, press button 1 -> score=1, moles unchanged, SHOW continues; repeat twice more -> score floors at 0.
- Let SHOW expire with speed=9 -> miss_pulse on cycle 11 after the SHOW start, miss_count=1, no score change; run 64 rounds -> no two consecutive identical mole indices and every index 0..NUM_MOLES-1 occurs.
- NUM_MOLES=5, SCORE_WIDTH=4: force 20 hits -> score saturates at 15; lit button pressed together with another -> treated as wrong, score=14.
- Drop game mid-SHOW with score=7 -> next cycle moles=0, state IDLE, score holds 7; raise game -> score=0; assert reset mid-GAP -> all outputs at reset values.

Source files
------------

// File: rtl/mole_game_pkg.sv
// Shared types and helpers for the whack-a-mole engine: FSM states,
// LFSR tap table and saturating counter arithmetic.
package mole_game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    SHOW = 2'd2
  } state_t;

  // Maximal-length tap masks; bit k set means register bit k feeds the XOR.
  function automatic logic [15:0] lfsr_taps(input int width);
    logic [15:0] taps;
    case (width)
      4:       taps = 16'h000C;
      5:       taps = 16'h0014;
      6:       taps = 16'h0030;
      7:       taps = 16'h0060;
      8:       taps = 16'h00B8;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0829;
      13:      taps = 16'h100D;
      14:      taps = 16'h2015;
      15:      taps = 16'h6000;
      16:      taps = 16'hD008;
      default: taps = 16'h0000;
    endcase
    return taps;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] value,
                                          input logic [15:0] max_value);
    return (value >= max_value) ? max_value : value + 16'd1;
  endfunction

  function automatic logic [15:0] sat_dec(input logic [15:0] value);
    return (value == 16'd0) ? 16'd0 : value - 16'd1;
  endfunction

endpackage

// File: rtl/lfsr_rng.sv
// Free-running Fibonacci LFSR; shifts left every cycle, feedback enters bit 0.
module lfsr_rng
  import mole_game_pkg::*;
#(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED = WIDTH'(8'hA5)
) (
  input  logic             clock,
  input  logic             reset,
  output logic [WIDTH-1:0] value
);

  localparam logic [15:0]      TAPS_ALL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];

  logic feedback;

  assign feedback = ^(value & TAPS);

  always_ff @(posedge clock) begin
    if (reset) begin
      value <= SEED;
    end else begin
      value <= {value[WIDTH-2:0], feedback};
    end
  end

endmodule

// File: rtl/mole_game_engine.sv
// Whack-a-mole engine: mole picking, show/gap timing, press judging and
// scoring for NUM_MOLES buttons. All outputs are registered.
module mole_game_engine
  import mole_game_pkg::*;
#(
  parameter int                    NUM_MOLES   = 3,
  parameter int                    LFSR_WIDTH  = 8,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED   = LFSR_WIDTH'(8'hA5),
  parameter int                    CNT_WIDTH   = 28,
  parameter int                    SCORE_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   game,
  input  logic [NUM_MOLES-1:0]   buttons,
  input  logic [CNT_WIDTH-1:0]   speed,
  input  logic [CNT_WIDTH-1:0]   gap,
  output logic [NUM_MOLES-1:0]   moles,
  output logic [SCORE_WIDTH-1:0] score,
  output logic [SCORE_WIDTH-1:0] miss_count,
  output logic                   hit_pulse,
  output logic                   miss_pulse,
  output logic                   active
);

  localparam int                     IW         = $clog2(NUM_MOLES);
  localparam int                     IWP        = IW + 1;
  localparam logic [IW:0]            MOLE_COUNT = IWP'(NUM_MOLES);
  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX  = '1;

  state_t                 state, state_n;
  logic [CNT_WIDTH-1:0]   timer, timer_n;
  logic [NUM_MOLES-1:0]   moles_n;
  logic [SCORE_WIDTH-1:0] score_n, miss_count_n;
  logic                   hit_n, miss_n, active_n;
  logic [IW-1:0]          prev_idx, prev_idx_n;
  logic [NUM_MOLES-1:0]   btn_q, btn_edge;

  logic [LFSR_WIDTH-1:0]  lfsr_value;
  logic [IW-1:0]          idx_raw, idx_fold, pick_idx;
  logic [IW:0]            idx_step;
  logic [NUM_MOLES-1:0]   pick_onehot;
  logic [SCORE_WIDTH-1:0] score_up, score_down, miss_up;
  logic                   unused_lfsr_bits;

  lfsr_rng #(
    .WIDTH (LFSR_WIDTH),
    .SEED  (LFSR_SEED)
  ) u_rng (
    .clock (clock),
    .reset (reset),
    .value (lfsr_value)
  );

  assign unused_lfsr_bits = ^lfsr_value[LFSR_WIDTH-1:IW];

  // Fold the raw index into range, then step past the previous mole.
  assign idx_raw     = lfsr_value[IW-1:0];
  assign idx_fold    = ({1'b0, idx_raw} >= MOLE_COUNT) ? IW'({1'b0, idx_raw} - MOLE_COUNT)
                                                       : idx_raw;
  assign idx_step    = {1'b0, idx_fold} + IWP'(1);
  assign pick_idx    = (idx_fold != prev_idx) ? idx_fold
                     : (idx_step == MOLE_COUNT) ? '0 : idx_step[IW-1:0];
  assign pick_onehot = NUM_MOLES'(1) << pick_idx;

  assign btn_edge   = buttons & ~btn_q;
  assign score_up   = SCORE_WIDTH'(sat_inc(16'(score), 16'(SCORE_MAX)));
  assign score_down = SCORE_WIDTH'(sat_dec(16'(score)));
  assign miss_up    = SCORE_WIDTH'(sat_inc(16'(miss_count), 16'(SCORE_MAX)));

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      moles      <= '0;
      score      <= '0;
      miss_count <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      active     <= 1'b0;
      prev_idx   <= '0;
      btn_q      <= '0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      moles      <= moles_n;
      score      <= score_n;
      miss_count <= miss_count_n;
      hit_pulse  <= hit_n;
      miss_pulse <= miss_n;
      active     <= active_n;
      prev_idx   <= prev_idx_n;
      btn_q      <= buttons;
    end
  end

  always_comb begin
    state_n      = state;
    timer_n      = timer;
    moles_n      = moles;
    score_n      = score;
    miss_count_n = miss_count;
    hit_n        = 1'b0;
    miss_n       = 1'b0;
    prev_idx_n   = prev_idx;

    if (!game) begin
      state_n = IDLE;
      moles_n = '0;
    end else begin
      case (state)
        IDLE: begin
          moles_n      = '0;
          score_n      = '0;
          miss_count_n = '0;
          timer_n      = gap;
          state_n      = GAP;
        end
        GAP: begin
          moles_n = '0;
          if (timer == '0) begin
            prev_idx_n = pick_idx;
            moles_n    = pick_onehot;
            timer_n    = speed;
            state_n    = SHOW;
          end else begin
            timer_n = timer - CNT_WIDTH'(1);
          end
        end
        SHOW: begin
          if (btn_edge == moles) begin
            score_n = score_up;
            hit_n   = 1'b1;
            moles_n = '0;
            timer_n = gap;
            state_n = GAP;
          end else begin
            // A wrong press on the last cycle still times out below.
            if (btn_edge != '0) begin
              score_n = score_down;
            end
            if (timer == '0) begin
              miss_count_n = miss_up;
              miss_n       = 1'b1;
              moles_n      = '0;
              timer_n      = gap;
              state_n      = GAP;
            end else begin
              timer_n = timer - CNT_WIDTH'(1);
            end
          end
        end
        default: begin
          moles_n = '0;
          state_n = IDLE;
        end
      endcase
    end

    active_n = (state_n != IDLE);
  end

endmodule
